branch_resolver: RTL and testbench
==================================

# branch_resolver

Branch decision unit in the ID stage of the pipelined MIPS core. It consumes the 1-bit equality flag from the 32-bit equality comparator and resolves BEQ/BNE. It waits while the hazard unit reports operands not yet forwarded, and produces a registered one-cycle redirect (PC select, target, IF/ID flush). It also keeps saturating branch and taken counters for the debug port.

## Interface
Parameters:
- CNT_W, 16, width of the statistics counters
- MAX_WAIT, 4, maximum consecutive stall cycles tolerated per branch before timeout

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- branch_valid  input  1  instruction in ID is a conditional branch
- branch_type  input  1  0 = BEQ, 1 = BNE
- eq  input  1  equality flag from the comparator (1 when rs == rt)
- operands_ready  input  1  hazard unit: comparator inputs are valid this cycle
- branch_target  input  32  computed target address of the branch in ID
- pc_src  output  1  registered; 1 = IF must load target_q
- target_q  output  32  registered branch target
- flush_if  output  1  registered; squash IF/ID register
- stall_id  output  1  combinational; freeze PC and IF/ID
- timeout  output  1  sticky; MAX_WAIT exceeded
- branch_count  output  CNT_W  resolved branches, saturating
- taken_count  output  CNT_W  taken branches, saturating

## Operation
- Decided: one clock; reset is asynchronous and active-high.
- States: IDLE, WAIT, RESOLVE.
- Accept condition: branch_valid=1 in IDLE, in WAIT, or in RESOLVE with pc_src=0. In RESOLVE with pc_src=1, the ID instruction is wrong-path and branch_valid is ignored.
- Accepted branch with operands_ready=1: taken = eq XOR branch_type. Go to RESOLVE next cycle with pc_src=taken, flush_if=taken, target_q=branch_target when taken (held otherwise). branch_count increments by 1; taken_count increments by 1 if taken.
- Accepted branch with operands_ready=0: stall_id=1 in the same cycle. Go to WAIT with wait_cnt=1.
- WAIT:
  - stall_id = !operands_ready.
  - On operands_ready=1, resolve as above.
  - Otherwise wait_cnt increments.
  - When wait_cnt reaches MAX_WAIT with operands_ready still 0: set timeout, return to IDLE without resolving. No counter change, no redirect.
- RESOLVE lasts exactly one cycle. Its next state is RESOLVE (back-to-back accepted branch), WAIT, or IDLE.
- Non-branch cycles (branch_valid=0 or ignored): next state is IDLE; pc_src and flush_if are 0.
- Counters saturate at 2^CNT_W-1 and never wrap. taken_count ≤ branch_count always.
- timeout clears only on reset.

## Timing
- Reset values: state IDLE, pc_src 0, flush_if 0, target_q 0, timeout 0, both counters 0, wait_cnt 0. stall_id is 0 while reset is asserted.
- Resolution latency: 1 cycle from the cycle with an accepted branch and operands_ready=1 to pc_src/flush_if high.
- pc_src and flush_if are single-cycle pulses, identical in value.
- stall_id has zero latency (combinational from branch_valid/operands_ready/state) and never depends on eq.
- Reset mid-WAIT or mid-RESOLVE: outputs drop to reset values immediately, with no redirect issued.
- operands_ready rising on the MAX_WAIT-th wait cycle: resolution wins and timeout stays 0.

## Test plan
- BEQ with eq=1, operands_ready=1, target 0x0000_0040 -> next cycle pc_src=1, flush_if=1, target_q=0x40; branch_count=1, taken_count=1.
- BNE with eq=1, ready -> next cycle pc_src=0, flush_if=0, target_q unchanged; branch_count=1, taken_count=0.
- BEQ with operands_ready low 2 cycles then high, eq=1 -> stall_id=1 for exactly 2 cycles, then 1 cycle later pc_src=1.
- operands_ready held low with MAX_WAIT=4 -> stall_id high 4 cycles, timeout=1, state IDLE, counters unchanged.
- Taken BEQ followed by branch_valid=1 in the RESOLVE cycle -> second branch ignored (counts stay 1/1). Repeat with a not-taken first branch -> second accepted, branch_count=2.
- Preload counters near saturation with CNT_W=2, then issue 5 taken branches -> both counters stop at 3. Assert reset mid-WAIT -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/branch_resolver.sv
// ----------------------------------------------------------------------------
// branch_resolver
//   ID-stage branch decision unit. Resolves BEQ/BNE from the comparator's
//   equality flag, waits (stalling PC and IF/ID) while the hazard unit says
//   the comparator operands are not forwarded yet, and issues a registered
//   one-cycle redirect. Saturating branch/taken counters feed the debug port.
//
// Handshake: a branch is "accepted" in any cycle where branch_valid=1 and the
//   unit is not in the redirect cycle (RESOLVE with pc_src=1), whose ID
//   instruction is wrong-path. An accepted branch completes in the cycle where
//   operands_ready=1; until then stall_id holds the branch in ID.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   branch_valid        ID holds a conditional branch
//   branch_type         0 = BEQ, 1 = BNE
//   eq                  comparator flag (rs == rt)
//   operands_ready      comparator inputs valid this cycle
//   branch_target       target address of the branch in ID
//   pc_src / flush_if   registered redirect pulse (identical values)
//   target_q            registered branch target
//   stall_id            combinational freeze of PC and IF/ID
//   timeout             sticky: a branch waited MAX_WAIT cycles
//   branch_count        resolved branches (saturating)
//   taken_count         taken branches (saturating)
//   dbg_state           current FSM state (0 IDLE, 1 WAIT, 2 RESOLVE)
// ----------------------------------------------------------------------------
module branch_resolver #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_valid,
  input  logic             branch_type,
  input  logic             eq,
  input  logic             operands_ready,
  input  logic [31:0]      branch_target,
  output logic             pc_src,
  output logic [31:0]      target_q,
  output logic             flush_if,
  output logic             stall_id,
  output logic             timeout,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [1:0]       dbg_state
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_pc_src;
  logic              r_flush_if;
  logic [31:0]       r_target_q;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_branch_count;
  logic [CNT_W-1:0]  r_taken_count;
  logic [WW-1:0]     r_wait_cnt;

  logic              w_accept;
  logic              w_taken;
  logic [WW-1:0]     w_next_wait;

  // In the redirect cycle the instruction in ID is being squashed.
  assign w_accept = branch_valid && !((r_state == S_RESOLVE) && r_pc_src);
  assign w_taken  = eq ^ branch_type;

  // Wait cycles counted so far including this one; the first stalled cycle
  // (entering from IDLE/RESOLVE) counts as 1.
  assign w_next_wait = (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : WW'(1);

  // Never a function of eq: the hazard unit must not see comparator glitches.
  assign stall_id = !reset && w_accept && !operands_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_pc_src       <= 1'b0;
      r_flush_if     <= 1'b0;
      r_target_q     <= '0;
      r_timeout      <= 1'b0;
      r_branch_count <= '0;
      r_taken_count  <= '0;
      r_wait_cnt     <= '0;
    end else begin
      r_pc_src   <= 1'b0;
      r_flush_if <= 1'b0;
      if (w_accept && operands_ready) begin
        r_state    <= S_RESOLVE;
        r_pc_src   <= w_taken;
        r_flush_if <= w_taken;
        r_wait_cnt <= '0;
        if (w_taken) r_target_q <= branch_target;
        if (r_branch_count != '1) r_branch_count <= r_branch_count + 1'b1;
        if (w_taken && (r_taken_count != '1)) r_taken_count <= r_taken_count + 1'b1;
      end else if (w_accept) begin
        if (w_next_wait == WAIT_MAX) begin
          // Give up on this branch: no redirect, no count.
          r_timeout  <= 1'b1;
          r_state    <= S_IDLE;
          r_wait_cnt <= '0;
        end else begin
          r_state    <= S_WAIT;
          r_wait_cnt <= w_next_wait;
        end
      end else begin
        r_state    <= S_IDLE;
        r_wait_cnt <= '0;
      end
    end
  end

  assign pc_src       = r_pc_src;
  assign flush_if     = r_flush_if;
  assign target_q     = r_target_q;
  assign timeout      = r_timeout;
  assign branch_count = r_branch_count;
  assign taken_count  = r_taken_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  localparam int CNT_W    = 2;
  localparam int MAX_WAIT = 4;

  logic             clk;
  logic             reset;
  logic             branch_valid;
  logic             branch_type;
  logic             eq;
  logic             operands_ready;
  logic [31:0]      branch_target;
  logic             pc_src;
  logic [31:0]      target_q;
  logic             flush_if;
  logic             stall_id;
  logic             timeout;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;
  logic [1:0]       dbg_state;

  int checks;
  int failures;

  branch_resolver #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .branch_valid   (branch_valid),
    .branch_type    (branch_type),
    .eq             (eq),
    .operands_ready (operands_ready),
    .branch_target  (branch_target),
    .pc_src         (pc_src),
    .target_q       (target_q),
    .flush_if       (flush_if),
    .stall_id       (stall_id),
    .timeout        (timeout),
    .branch_count   (branch_count),
    .taken_count    (taken_count),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bv, input logic bt, input logic e,
                       input logic rdy, input logic [31:0] tgt);
    branch_valid   = bv;
    branch_type    = bt;
    eq             = e;
    operands_ready = rdy;
    branch_target  = tgt;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;

    // Reset state; stall_id gated by reset even with a stalling request.
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hdead_beef);
    tick();
    tick();
    chk("rst_stall", stall_id, 0);
    chk("rst_pc_src", pc_src, 0);
    chk("rst_flush", flush_if, 0);
    chk("rst_target", target_q, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_bcnt", branch_count, 0);
    chk("rst_tcnt", taken_count, 0);
    chk("rst_state", dbg_state, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    tick();

    // BEQ taken, ready.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
    #1 chk("beq_stall", stall_id, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("beq_pc_src", pc_src, 1);
    chk("beq_flush", flush_if, 1);
    chk("beq_target", target_q, 32'h40);
    chk("beq_bcnt", branch_count, 1);
    chk("beq_tcnt", taken_count, 1);
    chk("beq_state", dbg_state, 2);
    tick();
    chk("beq_pulse_end", pc_src, 0);
    chk("beq_flush_end", flush_if, 0);
    chk("beq_idle", dbg_state, 0);

    // BNE with eq=1: not taken, target held.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("bne_pc_src", pc_src, 0);
    chk("bne_flush", flush_if, 0);
    chk("bne_target", target_q, 0);
    chk("bne_bcnt", branch_count, 1);
    chk("bne_tcnt", taken_count, 0);

    // BEQ waiting 2 cycles; eq toggles during the wait, stall must not care.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
    #1 chk("w2_stall0", stall_id, 1);
    tick();
    chk("w2_state", dbg_state, 1);
    eq = 1'b0;
    #1 chk("w2_stall1", stall_id, 1);
    eq = 1'b1;
    #1 chk("w2_stall1b", stall_id, 1);
    tick();
    operands_ready = 1'b1;
    #1 chk("w2_stall2", stall_id, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("w2_pc_src", pc_src, 1);
    chk("w2_target", target_q, 32'h100);
    chk("w2_bcnt", branch_count, 1);

    // operands_ready held low: 4 stall cycles, then timeout.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200);
    for (int i = 0; i < MAX_WAIT; i++) begin
      #1 chk($sformatf("to_stall%0d", i), stall_id, 1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("to_timeout", timeout, 1);
    chk("to_state", dbg_state, 0);
    chk("to_pc_src", pc_src, 0);
    chk("to_bcnt", branch_count, 0);
    chk("to_tcnt", taken_count, 0);
    chk("to_stall_after", stall_id, 0);
    tick();
    chk("to_sticky", timeout, 1);

    // Ready arrives on the last allowed wait cycle: resolution wins.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300);
    for (int i = 0; i < MAX_WAIT - 1; i++) tick();
    operands_ready = 1'b1;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("last_pc_src", pc_src, 1);
    chk("last_timeout", timeout, 0);
    chk("last_target", target_q, 32'h300);

    // Taken branch, then a branch in the redirect cycle: ignored.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0500);
    #1 chk("ign_stall", stall_id, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("ign_pc_src", pc_src, 0);
    chk("ign_state", dbg_state, 0);
    chk("ign_bcnt", branch_count, 1);
    chk("ign_tcnt", taken_count, 1);
    chk("ign_target", target_q, 32'h40);

    // Not-taken branch, then a taken branch back-to-back: accepted.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0600);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("b2b_pc_src", pc_src, 1);
    chk("b2b_state", dbg_state, 2);
    chk("b2b_target", target_q, 32'h600);
    chk("b2b_bcnt", branch_count, 2);
    chk("b2b_tcnt", taken_count, 1);

    // Five taken branches with CNT_W=2: both counters saturate at 3.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i));
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("sat_bcnt%0d", i), branch_count, (i < 3) ? i + 1 : 3);
      chk($sformatf("sat_tcnt%0d", i), taken_count, (i < 3) ? i + 1 : 3);
      tick();
    end

    // Reset mid-WAIT: outputs drop in the same cycle.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0700);
    tick();
    chk("mw_state", dbg_state, 1);
    #2 reset = 1'b1;
    #1;
    chk("mw_stall", stall_id, 0);
    chk("mw_state_rst", dbg_state, 0);
    chk("mw_bcnt", branch_count, 0);
    chk("mw_target", target_q, 0);
    tick();
    chk("mw_pc_src", pc_src, 0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Reset mid-RESOLVE: redirect pulse is killed immediately.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0800);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("mr_pc_src_pre", pc_src, 1);
    #2 reset = 1'b1;
    #1;
    chk("mr_pc_src", pc_src, 0);
    chk("mr_flush", flush_if, 0);
    chk("mr_target", target_q, 0);
    chk("mr_tcnt", taken_count, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
